set_scan_ctrl: RTL

- Sequencer for the candidate accumulator datapath.
- On a start pulse it clears the accumulator, then sweeps every point of a GRID x GRID lattice, four points per cycle, through the 4-lane lookup unit.
- It drives the accumulator enable aligned to the lookup latency, waits for the final sum to settle, and then returns the candidate count with a one-cycle valid pulse.

---
 rtl/set_scan_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/set_scan_ctrl.sv
// ---------------------------------------------------------------------------
// set_scan_ctrl
//
// Sequencer for the candidate accumulator datapath. A start request clears
// the accumulator, sweeps the GRID x GRID lattice four points per cycle
// through the 4-lane lookup unit, lets the delayed accumulator enables and
// the final accumulator update drain, then latches the accumulator output
// and flags it with a one-cycle valid pulse.
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      start request, honoured only while idle
//   busy_o       high while a scan is in progress
//   lu_valid_o   lookup issue strobe
//   lu_x_o       x of lane 0 (lane k tests lu_x_o+k)
//   lu_y_o       row being issued
//   acc_clear_o  accumulator synchronous clear
//   acc_en_o     accumulator enable, lu_valid_o delayed LU_LAT cycles
//   candidate_i  accumulator output
//   result_o     latched final count, held until the next completion
//   valid_o      one-cycle pulse marking a new result_o
// ---------------------------------------------------------------------------
`ifndef CANDIDATE_SZ
`define CANDIDATE_SZ 16
`endif

module set_scan_ctrl #(
   parameter int GRID    = 8,
   parameter int LU_LAT  = 2,
   parameter int COORD_W = 6,
   parameter int CAND_W  = `CANDIDATE_SZ
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   output logic               busy_o,
   output logic               lu_valid_o,
   output logic [COORD_W-1:0] lu_x_o,
   output logic [COORD_W-1:0] lu_y_o,
   output logic               acc_clear_o,
   output logic               acc_en_o,
   input  logic [CAND_W-1:0]  candidate_i,
   output logic [CAND_W-1:0]  result_o,
   output logic               valid_o
);

   // Number of issue cycles: four lattice points per cycle.
   localparam int G     = GRID * GRID / 4;
   localparam int CNT_W = (G > 1) ? $clog2(G) : 1;

   localparam logic [CNT_W-1:0]   LAST_ISSUE = CNT_W'(G - 1);
   localparam logic [2:0]         LAST_DRAIN = 3'(LU_LAT);
   // Lane-0 x of the final group in a row; the next step wraps to x=0.
   localparam logic [COORD_W-1:0] X_WRAP     = COORD_W'(GRID - 4);
   localparam logic [COORD_W-1:0] X_STEP     = COORD_W'(4);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_ISSUE = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [CNT_W-1:0]   issue_cnt_r;
   logic [CNT_W-1:0]   issue_cnt_s;
   logic [2:0]         drain_cnt_r;
   logic [2:0]         drain_cnt_s;
   logic [COORD_W-1:0] x_s;
   logic [COORD_W-1:0] y_s;
   logic               busy_s;
   logic               clear_s;
   logic               lu_valid_s;
   logic               valid_s;
   logic [CAND_W-1:0]  result_s;

   // Next-state logic; every output is precomputed from the next state so
   // that the registered outputs line up with the state they describe.
   always_comb begin
      state_s     = state_r;
      issue_cnt_s = issue_cnt_r;
      drain_cnt_s = drain_cnt_r;
      x_s         = '0;
      y_s         = '0;
      valid_s     = 1'b0;
      result_s    = result_o;

      case (state_r)
         S_IDLE: begin
            if (start_i) begin
               state_s = S_CLEAR;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_CLEAR: begin
            // First issue cycle starts at (0,0), which x_s/y_s default to.
            state_s     = S_ISSUE;
            issue_cnt_s = '0;
         end
         S_ISSUE: begin
            if (issue_cnt_r == LAST_ISSUE) begin
               // Coordinates fall back to 0 along with lu_valid_o.
               state_s     = S_DRAIN;
               drain_cnt_s = 3'd0;
            end else begin
               issue_cnt_s = issue_cnt_r + 1'b1;
               if (lu_x_o == X_WRAP) begin
                  x_s = '0;
                  y_s = lu_y_o + 1'b1;
               end else begin
                  x_s = lu_x_o + X_STEP;
                  y_s = lu_y_o;
               end
            end
         end
         S_DRAIN: begin
            // LU_LAT cycles for the last delayed enables plus one for the
            // accumulator register to absorb the final contribution.
            if (drain_cnt_r == LAST_DRAIN) begin
               state_s  = S_IDLE;
               valid_s  = 1'b1;
               result_s = candidate_i;
            end else begin
               drain_cnt_s = drain_cnt_r + 1'b1;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase

      busy_s     = (state_s != S_IDLE);
      clear_s    = (state_s == S_CLEAR);
      lu_valid_s = (state_s == S_ISSUE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= S_IDLE;
         issue_cnt_r <= '0;
         drain_cnt_r <= 3'd0;
         busy_o      <= 1'b0;
         acc_clear_o <= 1'b0;
         lu_valid_o  <= 1'b0;
         lu_x_o      <= '0;
         lu_y_o      <= '0;
         valid_o     <= 1'b0;
         result_o    <= '0;
      end else begin
         state_r     <= state_s;
         issue_cnt_r <= issue_cnt_s;
         drain_cnt_r <= drain_cnt_s;
         busy_o      <= busy_s;
         acc_clear_o <= clear_s;
         lu_valid_o  <= lu_valid_s;
         lu_x_o      <= x_s;
         lu_y_o      <= y_s;
         valid_o     <= valid_s;
         result_o    <= result_s;
      end
   end

   // Enable delay line matching the lookup latency. Because the issue phase
   // always follows the clear cycle, no enable can overlap a clear.
   if (LU_LAT == 0) begin : g_no_delay
      assign acc_en_o = lu_valid_o;
   end else begin : g_delay
      logic [LU_LAT-1:0] dly_r;

      // Shift lu_valid_o through LU_LAT stages.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            dly_r <= '0;
         end else begin
            dly_r <= (dly_r << 1) | LU_LAT'(lu_valid_o);
         end
      end

      assign acc_en_o = dly_r[LU_LAT-1];
   end

endmodule
